driver_activations_stream: RTL and testbench

//  Streaming successor of the combinational activation driver.
//  - Accepts MEM_BW-wide activation words from SRAM over a valid/ready handshake.
//  - Buffers them in a small FIFO.
//  - Serialises each word into LANES-wide beats of IO_DATA_WIDTH elements for the PE array.
//  - Sits between the activation memory read port and the PE-array activation inputs.
//  - Supports tile-end marking, sync flush and backpressure.

---
 rtl/driver_act_pkg.sv | 32 +++
 rtl/act_word_fifo.sv | 67 ++++++
 rtl/driver_activations_stream.sv | 153 +++++++++++++++
 tb/tb_driver_activations_stream.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/driver_act_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : driver_act_pkg                                                   |
// | Shared types, default geometry and element slicing for the activation      |
// | streaming driver.                                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package driver_act_pkg;

  localparam int DEF_IO_DATA_WIDTH = 8;
  localparam int DEF_MEM_BW        = 128;
  localparam int DEF_LANES         = 4;
  localparam int DEF_FIFO_DEPTH    = 2;

  localparam int ELEMS = DEF_MEM_BW / DEF_IO_DATA_WIDTH;
  localparam int BEATS = ELEMS / DEF_LANES;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drv_act_state_t;

  // Element 0 is the most significant element of the word.
  function automatic logic [DEF_IO_DATA_WIDTH-1:0] get_elem(
    input logic [DEF_MEM_BW-1:0] word,
    input int unsigned           e
  );
    return word[DEF_MEM_BW-1-e*DEF_IO_DATA_WIDTH -: DEF_IO_DATA_WIDTH];
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : act_word_fifo                                                    |
// | Small synchronous FIFO holding activation words plus their last-of-tile    |
// | tag, with a synchronous flush.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module act_word_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             flush_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full_out  = (r_count == (c_ptr_w+1)'(DEPTH));
  assign empty_out = (r_count == '0);
  assign w_do_push = push_in & ~full_out;
  assign w_do_pop  = pop_in & ~empty_out;
  assign data_out  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !flush_in) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/driver_activations_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : driver_activations_stream                                        |
// | Buffers MEM_BW-wide activation words and serialises them into LANES-wide   |
// | beats for the PE array. Define DRV_ACT_RELU_EN to zero negative elements.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module driver_activations_stream
  import driver_act_pkg::*;
#(
  parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter int MEM_BW        = DEF_MEM_BW,
  parameter int LANES         = DEF_LANES,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  localparam int c_idx_w      = $clog2((MEM_BW / IO_DATA_WIDTH) / LANES) + 1
) (
  input  logic                                clk,
  input  logic                                arst_n_in,
  input  logic                                flush_in,
  input  logic [MEM_BW-1:0]                   word_in,
  input  logic                                word_valid_in,
  input  logic                                word_last_in,
  output logic                                word_ready_out,
  output logic [LANES-1:0][IO_DATA_WIDTH-1:0] act_out,
  output logic                                act_valid_out,
  input  logic                                act_ready_in,
  output logic                                act_last_out,
  output logic [c_idx_w-1:0]                  beat_idx_out
);

  localparam int c_elems  = MEM_BW / IO_DATA_WIDTH;
  localparam int c_beats  = c_elems / LANES;
  localparam int c_beat_w = LANES * IO_DATA_WIDTH;

  drv_act_state_t r_state;
  drv_act_state_t w_state_nxt;
  logic [c_idx_w-1:0] r_cnt;
  logic [c_idx_w-1:0] w_cnt_nxt;
  logic [MEM_BW-1:0]  r_word;
  logic               r_last;

  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [MEM_BW:0]    w_fifo_dout;
  logic               w_beat_hs;
  logic               w_at_last;

  logic [c_beats-1:0][c_beat_w-1:0] w_beats;
  logic [c_beat_w-1:0]              w_beat;

  // Gating with the reset keeps the input port closed while held in reset.
  assign word_ready_out = arst_n_in & ~w_fifo_full;
  assign w_push         = word_valid_in & word_ready_out & ~flush_in;

  act_word_fifo #(
    .WIDTH (MEM_BW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .flush_in  (flush_in),
    .push_in   (w_push),
    .data_in   ({word_last_in, word_in}),
    .pop_in    (w_pop),
    .data_out  (w_fifo_dout),
    .full_out  (w_fifo_full),
    .empty_out (w_fifo_empty)
  );

  assign w_beat_hs = (r_state == STREAM) & act_ready_in;
  assign w_at_last = (r_cnt == c_idx_w'(c_beats - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = STREAM;
          w_cnt_nxt   = '0;
        end
      end
      STREAM: begin
        if (w_beat_hs) begin
          if (w_at_last) begin
            // Reload on the same edge so back-to-back words have no bubble.
            w_cnt_nxt = '0;
            if (!w_fifo_empty) w_pop = 1'b1;
            else               w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush_in) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) begin
        r_last <= w_fifo_dout[MEM_BW];
        r_word <= w_fifo_dout[MEM_BW-1:0];
      end
    end
  end

  for (genvar b = 0; b < c_beats; b++) begin : g_beat
    assign w_beats[b] = r_word[MEM_BW-1-b*c_beat_w -: c_beat_w];
  end

  always_comb begin
    w_beat = '0;
    for (int b = 0; b < c_beats; b++) begin
      if (r_cnt == c_idx_w'(b)) w_beat = w_beats[b];
    end
  end

  // Lane 0 takes the most significant element of the selected beat.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IO_DATA_WIDTH-1:0] w_raw;
    logic [IO_DATA_WIDTH-1:0] w_elem;
    assign w_raw = w_beat[c_beat_w-1-l*IO_DATA_WIDTH -: IO_DATA_WIDTH];
`ifdef DRV_ACT_RELU_EN
    assign w_elem = w_raw[IO_DATA_WIDTH-1] ? '0 : w_raw;
`else
    assign w_elem = w_raw;
`endif
    assign act_out[l] = (r_state == STREAM) ? w_elem : '0;
  end

  assign act_valid_out = (r_state == STREAM);
  assign act_last_out  = (r_state == STREAM) & w_at_last & r_last;
  assign beat_idx_out  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_driver_activations_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_driver_activations_stream                                     |
// | Directed self-checking bench for driver_activations_stream (8/128/4/2).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_driver_activations_stream;

  logic            clk = 1'b0;
  logic            arst_n_in = 1'b0;
  logic            flush_in = 1'b0;
  logic [127:0]    word_in = '0;
  logic            word_valid_in = 1'b0;
  logic            word_last_in = 1'b0;
  logic            word_ready_out;
  logic [3:0][7:0] act_out;
  logic            act_valid_out;
  logic            act_ready_in = 1'b0;
  logic            act_last_out;
  logic [2:0]      beat_idx_out;

  logic [31:0]     obs_beat;
  int              n_cmp = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  driver_activations_stream #(
    .IO_DATA_WIDTH (8),
    .MEM_BW        (128),
    .LANES         (4),
    .FIFO_DEPTH    (2)
  ) dut (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .flush_in       (flush_in),
    .word_in        (word_in),
    .word_valid_in  (word_valid_in),
    .word_last_in   (word_last_in),
    .word_ready_out (word_ready_out),
    .act_out        (act_out),
    .act_valid_out  (act_valid_out),
    .act_ready_in   (act_ready_in),
    .act_last_out   (act_last_out),
    .beat_idx_out   (beat_idx_out)
  );

  // Lane 0 in the top byte so beats read in memory order.
  assign obs_beat = {act_out[0], act_out[1], act_out[2], act_out[3]};

  function automatic logic [31:0] beat_of(input logic [127:0] w, input int b);
    logic [127:0] t;
    t = w;
    return t[127-32*b -: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #13;
    n_cmp++; if (word_ready_out !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0b want 0", word_ready_out); end
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", act_valid_out); end
    n_cmp++; if (act_last_out !== 1'b0) begin n_err++; $display("FAIL rst_last: got %0b want 0", act_last_out); end
    n_cmp++; if (obs_beat !== 32'h0) begin n_err++; $display("FAIL rst_act: got %h want 0", obs_beat); end
    n_cmp++; if (beat_idx_out !== 3'd0) begin n_err++; $display("FAIL rst_idx: got %0d want 0", beat_idx_out); end
    act_ready_in = 1'b1;
    @(negedge clk);
    arst_n_in = 1'b1;
    #1;
    n_cmp++; if (word_ready_out !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %0b want 1", word_ready_out); end
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp_b [4];
    exp_b = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    word_in = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    word_valid_in = 1'b1;
    word_last_in = 1'b0;
    tick();
    word_valid_in = 1'b0;
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_latency: valid got %0b want 0", act_valid_out); end
    for (int b = 0; b < 4; b++) begin
      tick();
      n_cmp++; if (act_valid_out !== 1'b1) begin n_err++; $display("FAIL basic_valid b%0d: got %0b want 1", b, act_valid_out); end
      n_cmp++; if (obs_beat !== exp_b[b]) begin n_err++; $display("FAIL basic_data b%0d: got %h want %h", b, obs_beat, exp_b[b]); end
      n_cmp++; if (beat_idx_out !== 3'(b)) begin n_err++; $display("FAIL basic_idx b%0d: got %0d want %0d", b, beat_idx_out, b); end
    end
    tick();
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_end: valid got %0b want 0", act_valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] w [3];
    logic exp_valid, exp_ready;
    w[0] = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    w[1] = 128'h10111213_14151617_18191A1B_1C1D1E1F;
    w[2] = 128'h20212223_24252627_28292A2B_2C2D2E2F;
    word_in = w[0];
    word_valid_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      exp_valid = (k >= 2) && (k <= 13);
      exp_ready = !((k >= 3) && (k <= 5));
      n_cmp++; if (act_valid_out !== exp_valid) begin n_err++; $display("FAIL b2b_valid k%0d: got %0b want %0b", k, act_valid_out, exp_valid); end
      n_cmp++; if (word_ready_out !== exp_ready) begin n_err++; $display("FAIL b2b_ready k%0d: got %0b want %0b", k, word_ready_out, exp_ready); end
      if (exp_valid) begin
        n_cmp++;
        if (obs_beat !== beat_of(w[(k-2)/4], (k-2)%4) || beat_idx_out !== 3'((k-2)%4)) begin
          n_err++;
          $display("FAIL b2b_beat k%0d: got %h idx %0d want %h idx %0d", k, obs_beat, beat_idx_out, beat_of(w[(k-2)/4], (k-2)%4), (k-2)%4);
        end
      end
      if (k == 1) word_in = w[1];
      if (k == 2) word_in = w[2];
      if (k == 3) word_valid_in = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] w;
    w = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    word_in = w;
    word_valid_in = 1'b1;
    tick();
    word_valid_in = 1'b0;
    repeat (3) tick();
    n_cmp++; if (beat_idx_out !== 3'd2) begin n_err++; $display("FAIL bp_pre: idx got %0d want 2", beat_idx_out); end
    act_ready_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (act_valid_out !== 1'b1 || obs_beat !== beat_of(w, 2) || beat_idx_out !== 3'd2 || act_last_out !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold c%0d: got v%0b %h idx %0d want v1 %h idx 2", c, act_valid_out, obs_beat, beat_idx_out, beat_of(w, 2));
      end
    end
    act_ready_in = 1'b1;
    tick();
    n_cmp++; if (obs_beat !== beat_of(w, 3) || beat_idx_out !== 3'd3) begin n_err++; $display("FAIL bp_resume: got %h idx %0d want %h idx 3", obs_beat, beat_idx_out, beat_of(w, 3)); end
    tick();
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL bp_end: valid got %0b want 0", act_valid_out); end
  endtask

  task automatic test_last();
    logic exp_last, exp_valid;
    word_in = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    word_valid_in = 1'b1;
    word_last_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_last = (k == 9);
      exp_valid = (k >= 2) && (k <= 9);
      n_cmp++; if (act_last_out !== exp_last) begin n_err++; $display("FAIL last_flag k%0d: got %0b want %0b", k, act_last_out, exp_last); end
      n_cmp++; if (act_valid_out !== exp_valid) begin n_err++; $display("FAIL last_valid k%0d: got %0b want %0b", k, act_valid_out, exp_valid); end
      if (k == 1) begin
        word_in = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
        word_last_in = 1'b1;
      end
      if (k == 2) begin
        word_valid_in = 1'b0;
        word_last_in = 1'b0;
      end
    end
  endtask

  task automatic test_flush();
    logic [127:0] w3;
    w3 = 128'h55667788_99AABBCC_DDEEFF00_11223344;
    word_in = 128'h01010101_02020202_03030303_04040404;
    word_valid_in = 1'b1;
    tick();
    word_in = 128'h05050505_06060606_07070707_08080808;
    tick();
    word_valid_in = 1'b0;
    tick();
    n_cmp++; if (beat_idx_out !== 3'd1 || act_valid_out !== 1'b1) begin n_err++; $display("FAIL flush_pre: got v%0b idx %0d want v1 idx 1", act_valid_out, beat_idx_out); end
    flush_in = 1'b1;
    word_in = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    word_valid_in = 1'b1;
    #1;
    n_cmp++; if (word_ready_out !== 1'b1) begin n_err++; $display("FAIL flush_offer_ready: got %0b want 1", word_ready_out); end
    tick();
    flush_in = 1'b0;
    word_valid_in = 1'b0;
    n_cmp++; if (act_valid_out !== 1'b0 || beat_idx_out !== 3'd0) begin n_err++; $display("FAIL flush_idle: got v%0b idx %0d want v0 idx 0", act_valid_out, beat_idx_out); end
    tick();
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL flush_empty: valid got %0b want 0", act_valid_out); end
    word_in = w3;
    word_valid_in = 1'b1;
    tick();
    word_valid_in = 1'b0;
    tick();
    n_cmp++; if (act_valid_out !== 1'b1 || beat_idx_out !== 3'd0 || obs_beat !== beat_of(w3, 0)) begin n_err++; $display("FAIL flush_restart: got v%0b %h idx %0d want v1 %h idx 0", act_valid_out, obs_beat, beat_idx_out, beat_of(w3, 0)); end
    repeat (4) tick();
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL flush_drain: valid got %0b want 0", act_valid_out); end
  endtask

  task automatic test_relu();
    logic [31:0] e0, e1;
`ifdef DRV_ACT_RELU_EN
    e0 = 32'h007F0001;
    e1 = 32'h00020304;
`else
    e0 = 32'h807FFF01;
    e1 = 32'hFE020304;
`endif
    word_in = 128'h807FFF01_FE020304_00000000_00000000;
    word_valid_in = 1'b1;
    tick();
    word_valid_in = 1'b0;
    tick();
    n_cmp++; if (obs_beat !== e0) begin n_err++; $display("FAIL relu_b0: got %h want %h", obs_beat, e0); end
    tick();
    n_cmp++; if (obs_beat !== e1) begin n_err++; $display("FAIL relu_b1: got %h want %h", obs_beat, e1); end
    repeat (3) tick();
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL relu_drain: valid got %0b want 0", act_valid_out); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] wn;
    wn = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
    word_in = 128'h77777777_66666666_55555555_44444444;
    word_valid_in = 1'b1;
    tick();
    word_valid_in = 1'b0;
    repeat (3) tick();
    n_cmp++; if (beat_idx_out !== 3'd2) begin n_err++; $display("FAIL rmid_pre: idx got %0d want 2", beat_idx_out); end
    #2;
    arst_n_in = 1'b0;
    #1;
    n_cmp++;
    if (act_valid_out !== 1'b0 || act_last_out !== 1'b0 || obs_beat !== 32'h0 || beat_idx_out !== 3'd0 || word_ready_out !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async: got v%0b l%0b %h idx %0d rdy %0b want all 0", act_valid_out, act_last_out, obs_beat, beat_idx_out, word_ready_out);
    end
    tick();
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();
    n_cmp++; if (act_valid_out !== 1'b0) begin n_err++; $display("FAIL rmid_discard: valid got %0b want 0", act_valid_out); end
    word_in = wn;
    word_valid_in = 1'b1;
    tick();
    word_valid_in = 1'b0;
    tick();
    n_cmp++; if (obs_beat !== beat_of(wn, 0) || beat_idx_out !== 3'd0 || act_valid_out !== 1'b1) begin n_err++; $display("FAIL rmid_b0: got v%0b %h idx %0d want v1 %h idx 0", act_valid_out, obs_beat, beat_idx_out, beat_of(wn, 0)); end
    tick();
    n_cmp++; if (obs_beat !== beat_of(wn, 1) || beat_idx_out !== 3'd1) begin n_err++; $display("FAIL rmid_b1: got %h idx %0d want %h idx 1", obs_beat, beat_idx_out, beat_of(wn, 1)); end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_last();
    test_flush();
    test_relu();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
